// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped I/O controller.
//   - cpu bus command codes (MREAD, MWRITE, MNONE; code 0 behaves as MNONE)
//   - controller FSM state encoding
//   - decode target encoding
package mmio_pkg;

  localparam logic [1:0] MREAD  = 2'd1;
  localparam logic [1:0] MWRITE = 2'd2;
  localparam logic [1:0] MNONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    T_RAM  = 2'd0,
    T_OUT  = 2'd1,
    T_IN   = 2'd2,
    T_NONE = 2'd3
  } tgt_e;

endpackage

// File: rtl/mmio_bus_ctrl_if.sv
// mmio_bus_ctrl_if: cpu memory-port bus between the cpu (master) and the
// MMIO controller (slave).
//   mem_cmd    master->slave  command (MREAD / MWRITE / MNONE)
//   mem_addr   master->slave  word address
//   write_data master->slave  write data
//   read_data  slave->master  registered read data, valid with mem_ready
//   mem_ready  slave->master  one-cycle completion pulse
//   bus_err    slave->master  one-cycle pulse with mem_ready on unmapped access
interface mmio_bus_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              mem_ready;
  logic              bus_err;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, mem_ready, bus_err
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, mem_ready, bus_err
  );
endinterface

// File: rtl/mmio_in_sync.sv
// mmio_in_sync: two-flop synchroniser for the asynchronous input ports.
//   clk   in  clock
//   reset in  asynchronous active-high reset, clears both stages
//   d     in  WIDTH asynchronous input bits
//   q     out WIDTH synchronised bits (two cycles behind d)
module mmio_in_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: memory-mapped I/O controller between the cpu memory port and
// a RAM, NUM_OUT writable output registers and NUM_IN read-only input ports.
//   clk, reset  clock and asynchronous active-high reset
//   bus         cpu bus (slave side): cmd/addr/wdata in, read_data/mem_ready/bus_err out
//   ram_addr    RAM word address (low bits of mem_addr, combinational)
//   ram_write   RAM write strobe, one cycle, only in IDLE on an accepted RAM write
//   ram_din     RAM write data (write_data, combinational)
//   ram_dout    RAM read data, valid RAM_LAT cycles after ram_addr
//   out_regs    output registers, register k at [k*DATA_W +: DATA_W]
//   in_ports    asynchronous input ports, port k at [k*DATA_W +: DATA_W]
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                RAM_AW   = 8,
  parameter int                RAM_LAT  = 1,
  parameter int                NUM_OUT  = 2,
  parameter int                NUM_IN   = 2,
  parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'('h100),
  parameter logic [ADDR_W-1:0] IN_BASE  = ADDR_W'('h140)
) (
  input  logic                      clk,
  input  logic                      reset,
  mmio_bus_ctrl_if.slave            bus,
  output logic [RAM_AW-1:0]         ram_addr,
  output logic                      ram_write,
  output logic [DATA_W-1:0]         ram_din,
  input  logic [DATA_W-1:0]         ram_dout,
  output logic [NUM_OUT*DATA_W-1:0] out_regs,
  input  logic [NUM_IN*DATA_W-1:0]  in_ports
);
  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]         read_data_q, read_data_d;
  logic                      mem_ready_q, mem_ready_d;
  logic                      bus_err_q, bus_err_d;
  logic [NUM_OUT*DATA_W-1:0] out_regs_q, out_regs_d;
  logic [NUM_IN*DATA_W-1:0]  in_sync;

  tgt_e tgt;
  int   off_out;
  int   off_in;
  logic cmd_rd;
  logic cmd_wr;

  mmio_in_sync #(.WIDTH(NUM_IN*DATA_W)) u_in_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_ports),
    .q     (in_sync)
  );

  // Address decode. RAM owns the lower half outright; OUT is tested before IN
  // so that an overlapping IN range is shadowed by OUT.
  always_comb begin
    off_out = int'(bus.mem_addr) - int'(OUT_BASE);
    off_in  = int'(bus.mem_addr) - int'(IN_BASE);
    cmd_rd  = (bus.mem_cmd == MREAD);
    cmd_wr  = (bus.mem_cmd == MWRITE);
    tgt     = T_NONE;
    if (!bus.mem_addr[ADDR_W-1])
      tgt = T_RAM;
    else if (off_out >= 0 && off_out < NUM_OUT)
      tgt = T_OUT;
    else if (off_in >= 0 && off_in < NUM_IN)
      tgt = T_IN;
  end

  // Next-state logic. Every I/O action happens at the accept edge, so WAIT only
  // ever serves a RAM read and nothing from the decode needs to be held.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    out_regs_d  = out_regs_q;
    bus_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_rd || cmd_wr) begin
          state_d = DONE;
          unique case (tgt)
            T_RAM: begin
              if (cmd_rd) begin
                state_d = WAIT;
                cnt_d   = CNT_W'(RAM_LAT - 1);
              end
            end
            T_OUT: begin
              if (cmd_rd)
                read_data_d = out_regs_q[off_out*DATA_W +: DATA_W];
              else
                out_regs_d[off_out*DATA_W +: DATA_W] = bus.write_data;
            end
            T_IN: begin
              // Input ports are read-only; a write there is silently dropped.
              if (cmd_rd)
                read_data_d = in_sync[off_in*DATA_W +: DATA_W];
            end
            default: begin
              if (cmd_rd)
                read_data_d = '0;
              bus_err_d = 1'b1;
            end
          endcase
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          read_data_d = ram_dout;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_ready_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      out_regs_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      mem_ready_q <= mem_ready_d;
      bus_err_q   <= bus_err_d;
      out_regs_q  <= out_regs_d;
    end
  end

  // The RAM write strobe is combinational so the RAM captures data on the
  // accept edge itself; held low through reset.
  assign ram_write     = !reset && (state_q == IDLE) && cmd_wr && (tgt == T_RAM);
  assign ram_addr      = bus.mem_addr[RAM_AW-1:0];
  assign ram_din       = bus.write_data;
  assign out_regs      = out_regs_q;
  assign bus.read_data = read_data_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: directed bench for mmio_bus_ctrl. Two instances are built,
// one with RAM_LAT=1 (dut1) and one with RAM_LAT=3 (dut3), each backed by a
// behavioural RAM with the matching read latency.
module tb_mmio_bus_ctrl;
  import mmio_pkg::*;

  logic clk;
  logic rst1, rst3;

  mmio_bus_ctrl_if #(.ADDR_W(9), .DATA_W(16)) bus1 ();
  mmio_bus_ctrl_if #(.ADDR_W(9), .DATA_W(16)) bus3 ();

  logic [7:0]  ram_addr1, ram_addr3;
  logic        ram_write1, ram_write3;
  logic [15:0] ram_din1, ram_din3;
  logic [15:0] ram_dout1, ram_dout3;
  logic [31:0] out1, out3;
  logic [31:0] in1, in3;

  mmio_bus_ctrl #(.RAM_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst1), .bus(bus1),
    .ram_addr(ram_addr1), .ram_write(ram_write1), .ram_din(ram_din1),
    .ram_dout(ram_dout1), .out_regs(out1), .in_ports(in1)
  );

  mmio_bus_ctrl #(.RAM_LAT(3)) u_dut3 (
    .clk(clk), .reset(rst3), .bus(bus3),
    .ram_addr(ram_addr3), .ram_write(ram_write3), .ram_din(ram_din3),
    .ram_dout(ram_dout3), .out_regs(out3), .in_ports(in3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAMs: synchronous write, read pipeline of depth RAM_LAT.
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  logic [15:0] pipe1;
  logic [15:0] pipe3 [3];

  always @(posedge clk) begin
    if (ram_write1) mem1[ram_addr1] <= ram_din1;
    pipe1 <= mem1[ram_addr1];
    if (ram_write3) mem3[ram_addr3] <= ram_din3;
    pipe3[0] <= mem3[ram_addr3];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign ram_dout1 = pipe1;
  assign ram_dout3 = pipe3[2];

  int rw_cnt1 = 0;
  int rw_cnt3 = 0;
  int rdy_cnt3 = 0;
  always @(posedge clk) begin
    if (ram_write1) rw_cnt1++;
    if (ram_write3) rw_cnt3++;
  end
  always @(negedge clk) if (bus3.mem_ready) rdy_cnt3++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] wd);
    if (sel == 1) begin
      bus1.mem_cmd = cmd; bus1.mem_addr = addr; bus1.write_data = wd;
    end else begin
      bus3.mem_cmd = cmd; bus3.mem_addr = addr; bus3.write_data = wd;
    end
  endtask

  // One complete transaction: present the command, wait (bounded) for
  // mem_ready, sample the response, drop the command, then confirm that
  // mem_ready lasted a single cycle.
  task automatic txn(input int sel, input logic [1:0] cmd, input logic [8:0] addr,
                     input logic [15:0] wd, output int lat, output logic [15:0] rd,
                     output logic err);
    logic rdy;
    @(negedge clk);
    drive(sel, cmd, addr, wd);
    lat = 99; rd = '0; err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      rdy = (sel == 1) ? bus1.mem_ready : bus3.mem_ready;
      if (rdy) begin
        lat = n;
        rd  = (sel == 1) ? bus1.read_data : bus3.read_data;
        err = (sel == 1) ? bus1.bus_err : bus3.bus_err;
        break;
      end
    end
    drive(sel, MNONE, addr, wd);
    @(posedge clk); #1;
    rdy = (sel == 1) ? bus1.mem_ready : bus3.mem_ready;
    chk("ready_one_cycle", 32'(rdy), 32'd0);
  endtask

  int          lat;
  logic [15:0] rd;
  logic        err;
  logic [3:0]  seq;
  int          base;

  initial begin
    for (int i = 0; i < 256; i++) begin mem1[i] = '0; mem3[i] = '0; end
    rst1 = 1'b1; rst3 = 1'b1;
    drive(1, MNONE, '0, '0);
    drive(3, MNONE, '0, '0);
    in1 = 32'h0000_003C;
    in3 = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read_data", 32'(bus1.read_data), 32'd0);
    chk("rst_mem_ready", 32'(bus1.mem_ready), 32'd0);
    chk("rst_bus_err",   32'(bus1.bus_err),   32'd0);
    chk("rst_out_regs",  out1,                32'd0);
    chk("rst_ram_write", 32'(ram_write1),     32'd0);
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;

    // OUT register write
    txn(1, MWRITE, 9'h100, 16'h0005, lat, rd, err);
    chk("out_wr_lat",   lat,                32'd1);
    chk("out_wr_reg0",  32'(out1[15:0]),    32'h0005);
    chk("out_wr_noram", rw_cnt1,            32'd0);

    // RAM write then read, latency 1
    txn(1, MWRITE, 9'h010, 16'hBEEF, lat, rd, err);
    chk("ram_wr_lat1",  lat,     32'd1);
    chk("ram_wr_strb1", rw_cnt1, 32'd1);
    txn(1, MREAD, 9'h010, 16'h0000, lat, rd, err);
    chk("ram_rd_lat1",  lat,        32'd2);
    chk("ram_rd_data1", 32'(rd),    32'hBEEF);
    chk("ram_rd_err1",  32'(err),   32'd0);
    chk("ram_rd_strb1", rw_cnt1,    32'd1);

    // RAM write then read, latency 3
    txn(3, MWRITE, 9'h010, 16'hBEEF, lat, rd, err);
    chk("ram_wr_lat3",  lat,     32'd1);
    chk("ram_wr_strb3", rw_cnt3, 32'd1);
    txn(3, MREAD, 9'h010, 16'h0000, lat, rd, err);
    chk("ram_rd_lat3",  lat,     32'd4);
    chk("ram_rd_data3", 32'(rd), 32'hBEEF);

    // Input ports through the synchroniser, OUT readback, writes keep read_data
    @(negedge clk);
    in1[31:16] = 16'h00A5;
    repeat (3) @(posedge clk);
    txn(1, MREAD, 9'h141, 16'h0000, lat, rd, err);
    chk("in1_lat",  lat,     32'd1);
    chk("in1_data", 32'(rd), 32'h00A5);
    txn(1, MREAD, 9'h140, 16'h0000, lat, rd, err);
    chk("in0_data", 32'(rd), 32'h003C);
    txn(1, MWRITE, 9'h101, 16'h1234, lat, rd, err);
    chk("wr_keeps_rdata", 32'(rd), 32'h003C);
    chk("out_regs_both",  out1,    32'h1234_0005);
    txn(1, MREAD, 9'h101, 16'h0000, lat, rd, err);
    chk("out1_readback", 32'(rd), 32'h1234);
    txn(1, MREAD, 9'h100, 16'h0000, lat, rd, err);
    chk("out0_readback", 32'(rd), 32'h0005);
    chk("io_rd_err",     32'(err), 32'd0);

    // Unmapped accesses, including the addresses just past each range
    txn(1, MREAD, 9'h1FF, 16'h0000, lat, rd, err);
    chk("unmap_rd_lat",  lat,      32'd1);
    chk("unmap_rd_err",  32'(err), 32'd1);
    chk("unmap_rd_data", 32'(rd),  32'd0);
    txn(1, MWRITE, 9'h1FF, 16'hFFFF, lat, rd, err);
    chk("unmap_wr_err",  32'(err), 32'd1);
    chk("unmap_wr_regs", out1,     32'h1234_0005);
    txn(1, MREAD, 9'h142, 16'h0000, lat, rd, err);
    chk("in_end_err",    32'(err), 32'd1);
    txn(1, MWRITE, 9'h102, 16'hFFFF, lat, rd, err);
    chk("out_end_err",   32'(err), 32'd1);
    chk("out_end_regs",  out1,     32'h1234_0005);

    // Reset while a latency-3 RAM read sits in WAIT
    txn(3, MWRITE, 9'h100, 16'h00AA, lat, rd, err);
    chk("d3_out_wr", 32'(out3[15:0]), 32'h00AA);
    base = rdy_cnt3;
    @(negedge clk);
    drive(3, MREAD, 9'h010, 16'h0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3 = 1'b1;
    #1;
    chk("wrst_mem_ready", 32'(bus3.mem_ready), 32'd0);
    chk("wrst_bus_err",   32'(bus3.bus_err),   32'd0);
    chk("wrst_read_data", 32'(bus3.read_data), 32'd0);
    chk("wrst_out_regs",  out3,                32'd0);
    chk("wrst_ram_write", 32'(ram_write3),     32'd0);
    @(negedge clk);
    drive(3, MNONE, 9'h000, 16'h0000);
    repeat (2) @(negedge clk);
    rst3 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("wrst_no_ready", rdy_cnt3 - base, 32'd0);
    txn(3, MREAD, 9'h010, 16'h0000, lat, rd, err);
    chk("wrst_next_lat",  lat,     32'd4);
    chk("wrst_next_data", 32'(rd), 32'hBEEF);

    // Command held for four cycles: two back-to-back transactions
    @(negedge clk);
    drive(1, MWRITE, 9'h100, 16'h0777);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seq[i] = bus1.mem_ready;
    end
    drive(1, MNONE, 9'h100, 16'h0777);
    chk("held_ready_seq", 32'(seq), 32'b0101);
    chk("held_out_regs",  out1,     32'h1234_0777);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
